// File: rtl/ram_pkg.sv
// Shared types and width helpers for the banked RAM pipeline.
package ram_pkg;

    typedef enum logic {INIT, RUN} state_t;

    // Bank field is sized for the largest supported bank count; the top zero-extends into it.
    localparam int BANK_SEL_W = 16;

    typedef struct packed {
        logic [BANK_SEL_W-1:0] bank;
        logic                  we;
        logic                  err;
        logic                  valid;
    } pipe_t;

    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int idx_w(input int bank_words);
        return $clog2(bank_words);
    endfunction

    function automatic int bank_w(input int num_banks);
        return $clog2(num_banks);
    endfunction

endpackage

// File: rtl/ram_bank.sv
// Single-port synchronous bank: byte-enable write, registered read, no array reset.
module ram_bank #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [$clog2(WORDS)-1:0] idx,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DATA_W/8; i++)
                    if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/banked_ram_pipe.sv
// Multi-bank RAM with init sweep, address decode/error check and a 2-stage response pipe.
module banked_ram_pipe
    import ram_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int NUM_BANKS  = 8,
    parameter int BANK_WORDS = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);

    localparam int OFF  = off_w(DATA_W);
    localparam int IW   = idx_w(BANK_WORDS);
    localparam int BW   = bank_w(NUM_BANKS);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);

    state_t          state;
    logic [IW-1:0]   init_idx;
    pipe_t           p0;

    logic [IW-1:0]   idx;
    logic [BW-1:0]   bank;
    logic            addr_err;
    logic            accept;

    logic [NUM_BANKS-1:0]             bank_en;
    logic                             bank_we;
    logic [BE_W-1:0]                  bank_be;
    logic [IW-1:0]                    bank_idx;
    logic [DATA_W-1:0]                bank_wdata;
    logic [NUM_BANKS-1:0][DATA_W-1:0] bank_rdata;
    logic [DATA_W-1:0]                rd_mux;

    assign idx      = req_addr[OFF+IW-1:OFF];
    assign bank     = req_addr[OFF+IW+BW-1:OFF+IW];
    assign addr_err = (|(req_addr & OFF_MASK)) || (|(req_addr >> (OFF + IW + BW)));
    assign accept   = req_valid && req_ready;

    // During the sweep every bank is written in lockstep; afterwards only the decoded bank.
    always_comb begin
        bank_en    = '0;
        bank_we    = req_we;
        bank_be    = req_be;
        bank_idx   = idx;
        bank_wdata = req_wdata;
        if (state == INIT) begin
            bank_en    = '1;
            bank_we    = 1'b1;
            bank_be    = '1;
            bank_idx   = init_idx;
            bank_wdata = '0;
        end else if (accept && !addr_err) begin
            bank_en[bank] = 1'b1;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ram_bank #(.DATA_W(DATA_W), .WORDS(BANK_WORDS)) u_bank (
            .clk   (clk),
            .en    (bank_en[b]),
            .we    (bank_we),
            .be    (bank_be),
            .idx   (bank_idx),
            .wdata (bank_wdata),
            .rdata (bank_rdata[b])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            init_idx  <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_idx <= init_idx + 1'b1;
                    if (init_idx == '1) begin
                        state     <= RUN;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end
                end
                RUN: ;
                default: state <= INIT;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            if (p0.bank == BANK_SEL_W'(b)) rd_mux = bank_rdata[b];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0        <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            p0.valid  <= accept;
            p0.we     <= req_we;
            p0.err    <= addr_err;
            p0.bank   <= BANK_SEL_W'(bank);
            rsp_valid <= p0.valid;
            rsp_err   <= p0.valid && p0.err;
            rsp_rdata <= (p0.valid && !p0.we && !p0.err) ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_banked_ram_pipe.sv
// Scoreboard bench for banked_ram_pipe: reference memory model, in-order response queue.
module tb_banked_ram_pipe;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    banked_ram_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mem_model [0:2047];
    int          n_chk = 0;
    int          n_pass = 0;
    int          run_len = 0;
    int          max_run = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rsp_valid) begin
                exp_t e;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (sbq.size() == 0) begin
                    chk("stale_rsp", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rdata", rsp_rdata, e.rdata);
                    chk("err", 32'(rsp_err), 32'(e.err));
                end
            end else begin
                run_len = 0;
            end
        end
    end

    // Drives one request for one edge; expectation comes from the reference model.
    task automatic req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata);
        exp_t        e;
        logic        err;
        logic [10:0] w;
        err = (addr[1:0] != 2'b0) || (addr[31:13] != 19'b0);
        w   = addr[12:2];
        e.err   = err;
        e.rdata = (!we && !err) ? mem_model[w] : 32'h0;
        if (we && !err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_model[w][8*i +: 8] = wdata[8*i +: 8];
        sbq.push_back(e);
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain", 32'(sbq.size()), 32'd0);
    endtask

    task automatic assert_reset(input string tag);
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_init_done"}, 32'(init_done), 32'd0);
        chk({tag, "_rdata"}, rsp_rdata, 32'd0);
        sbq.delete();
        for (int i = 0; i < 2048; i++) mem_model[i] = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!req_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_init_len"}, 32'(n), 32'd256);
        chk({tag, "_init_done"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 4'h0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        assert_reset("por");
        wait_init("por");

        req(1'b0, 4'h0, 32'h0000_1FFC, 32'h0);
        drain();

        req(1'b1, 4'hF, 32'h0000_0404, 32'hDEAD_BEEF);
        req(1'b0, 4'h0, 32'h0000_0404, 32'h0);
        drain();

        req(1'b1, 4'b0101, 32'h0000_0404, 32'h1122_3344);
        req(1'b0, 4'h0, 32'h0000_0404, 32'h0);
        drain();

        max_run = 0;
        for (int b = 0; b < 8; b++) req(1'b1, 4'hF, 32'(b) << 10, 32'(b));
        for (int b = 0; b < 8; b++) req(1'b0, 4'h0, 32'(b) << 10, 32'h0);
        drain();
        chk("burst_run", 32'(max_run), 32'd16);

        req(1'b0, 4'h0, 32'h0000_0402, 32'h0);
        req(1'b1, 4'hF, 32'h0000_2000, 32'hCAFE_F00D);
        req(1'b0, 4'h0, 32'h0000_0000, 32'h0);
        drain();

        assert_reset("mid_init");
        repeat (100) @(posedge clk);
        #1;
        chk("mid_init_ready", 32'(req_ready), 32'd0);
        assert_reset("restart");
        wait_init("restart");

        req(1'b1, 4'hF, 32'h0000_0404, 32'h5555_AAAA);
        drain();
        req(1'b0, 4'h0, 32'h0000_0404, 32'h0);
        req(1'b0, 4'h0, 32'h0000_0408, 32'h0);
        @(posedge clk);
        #1;
        chk("inflight_valid", 32'(rsp_valid), 32'd1);
        assert_reset("stream");
        wait_init("stream");
        req(1'b0, 4'h0, 32'h0000_0404, 32'h0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
